// File: rtl/controlador_contador_t_pkg.sv
// Shared state encoding and width default for the T flip-flop bank sequencer.
// No logic and no latency. The PRESET state is only reachable when CONTADOR_T_PRESET_EN is defined.
package controlador_contador_t_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4,
    ST_PRESET = 3'd5
  } state_t;

endpackage

// File: rtl/gerador_excitacao_t.sv
// Combinational next-count, toggle excitation, wrap and terminal detect for a WIDTH-bit T bank.
// Zero latency, no backpressure. CONTADOR_T_PRESET_EN makes all-ones a down-count reload point.
module gerador_excitacao_t #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  output logic [WIDTH-1:0] t_run,
  output logic             wrap,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] nxt;
  logic             reload;

  // Out-of-range values (q > limit) fold back onto the reload value, counted as a wrap.
  always_comb begin
    reload = 1'b0;
    nxt    = q;
    if (dir) begin
      reload = (q >= limit);
      nxt    = reload ? '0 : q + ONE;
    end else begin
      reload = (q == '0) || (q > limit);
`ifdef CONTADOR_T_PRESET_EN
      if (q == '1) reload = 1'b1;
`endif
      nxt    = reload ? limit : q - ONE;
    end
  end

  assign t_run   = q ^ nxt;
  assign wrap    = reload;
  assign at_term = dir ? (q == limit) : (q == '0);

endmodule

// File: rtl/controlador_contador_t.sv
// Sequencer for a bank of T flip-flops: CLEAR/LOAD/RUN/DONE FSM, outputs registered one cycle after decision.
// No backpressure (start/stop/load are level commands); CONTADOR_T_PRESET_EN adds a PRESET entry for down runs.
module controlador_contador_t
  import controlador_contador_t_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             ff_clr,
  output logic             ff_prst,
  output logic             ff_en,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state;
  logic [WIDTH-1:0] t_run;
  logic             gen_wrap;
  logic             at_term;

  gerador_excitacao_t #(.WIDTH(WIDTH)) u_gerador (
    .q       (q),
    .limit   (limit),
    .dir     (dir),
    .t_run   (t_run),
    .wrap    (gen_wrap),
    .at_term (at_term)
  );

`ifndef CONTADOR_T_PRESET_EN
  assign ff_prst = 1'b0;
`endif

  // Outputs are loaded with the values for the state being entered, so the bank
  // sees them at the following falling edge. Leaving CLEAR/PRESET already makes
  // the first count decision on the freshly cleared q.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      t       <= '0;
      ff_clr  <= 1'b0;
      ff_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
`ifdef CONTADOR_T_PRESET_EN
      ff_prst <= 1'b0;
`endif
    end else begin
      t       <= '0;
      ff_clr  <= 1'b0;
      ff_en   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
`ifdef CONTADOR_T_PRESET_EN
      ff_prst <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (start) begin
            ff_en <= 1'b1;
            busy  <= 1'b1;
`ifdef CONTADOR_T_PRESET_EN
            if (!dir) begin
              state   <= ST_PRESET;
              ff_prst <= 1'b1;
            end else begin
              state  <= ST_CLEAR;
              ff_clr <= 1'b1;
            end
`else
            state  <= ST_CLEAR;
            ff_clr <= 1'b1;
`endif
          end else if (load) begin
            state <= ST_LOAD;
            ff_en <= 1'b1;
            busy  <= 1'b1;
            t     <= q ^ load_val;
          end
        end
        ST_CLEAR, ST_PRESET, ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (one_shot && at_term) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_RUN;
            ff_en <= 1'b1;
            busy  <= 1'b1;
            t     <= t_run;
            wrap  <= gen_wrap;
          end
        end
        ST_LOAD: state <= ST_IDLE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_contador_t.sv
// Directed bench for controlador_contador_t with a behavioural T bank toggling on the falling edge.
// Default build only (CONTADOR_T_PRESET_EN undefined).
module tb_controlador_contador_t;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic       dir = 1'b1, one_shot = 1'b0;
  logic [3:0] limit = '0;
  logic [3:0] q = '0;
  logic [3:0] t;
  logic       ff_clr, ff_prst, ff_en, busy, done, wrap;

  logic       frc_en = 1'b0;
  logic [3:0] frc_val = '0;

  int n_vec = 0;
  int n_err = 0;

  controlador_contador_t #(.WIDTH(4)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .one_shot (one_shot),
    .limit    (limit),
    .q        (q),
    .t        (t),
    .ff_clr   (ff_clr),
    .ff_prst  (ff_prst),
    .ff_en    (ff_en),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  // T flip-flop bank; a forced value overrides everything for one edge.
  always @(negedge clk) begin
    if (frc_en)      q = frc_val;
    else if (ff_en) begin
      if (ff_clr)       q = 4'b0000;
      else if (ff_prst) q = 4'b1111;
      else              q = q ^ t;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic force_q(input logic [3:0] v);
    frc_val = v;
    frc_en  = 1'b1;
    @(negedge clk);
    #1;
    frc_en  = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    #1 clr_n = 1'b0;
    #2;
    chk("rst_t", t, 0);
    chk("rst_en", ff_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr", ff_clr, 0);
    chk("rst_prst", ff_prst, 0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Up free-run, limit 9
    dir = 1'b1; one_shot = 1'b0; limit = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("clr_pulse", ff_clr, 1);
    chk("clr_t", t, 0);
    chk("clr_busy", busy, 1);
    for (int i = 0; i <= 10; i++) begin
      n = i % 10;
      tick();
      chk("up9_q", q, n);
      chk("up9_t", t, n ^ ((n + 1) % 10));
      chk("up9_wrap", wrap, (n == 9) ? 1 : 0);
      if (n == 9) chk("up9_t_at9", t, 4'b1001);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("up9_stop_t", t, 0);
    chk("up9_stop_busy", busy, 0);

    // Free-run up limit 15, stop at q=3
    force_q(4'd0);
    limit = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("run_q2_t", t, 4'b0001);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_q", q, 3);
    chk("stop_t", t, 0);
    chk("stop_busy", busy, 0);
    tick();
    chk("stop_hold_q", q, 3);
    chk("stop_hold_en", ff_en, 0);

    // Load 1010 onto q=0
    force_q(4'd0);
    load = 1'b1; load_val = 4'b1010;
    tick();
    load = 1'b0;
    chk("load_t", t, 4'b1010);
    chk("load_en", ff_en, 1);
    chk("load_busy", busy, 1);
    tick();
    chk("load_q", q, 10);
    chk("load_idle_busy", busy, 0);
    chk("load_idle_t", t, 0);

    // Out-of-range q=12 with limit 9 counting up
    limit = 4'd9; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    force_q(4'd12);
    tick();
    chk("oor_t", t, 4'b1100);
    chk("oor_wrap", wrap, 1);
    tick();
    chk("oor_q", q, 0);
    chk("oor_next_t", t, 4'b0001);
    chk("oor_next_wrap", wrap, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Down one-shot from 0, limit 7: immediate terminal
    dir = 1'b0; one_shot = 1'b1; limit = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_os_clr_t", t, 0);
    tick();
    chk("dn_os_done", done, 1);
    chk("dn_os_t", t, 0);
    chk("dn_os_q", q, 0);
    tick();
    chk("dn_os_done_end", done, 0);
    chk("dn_os_idle_busy", busy, 0);
    chk("dn_os_idle_t", t, 0);

    // Up one-shot limit 2: 0,1,2 then done
    dir = 1'b1; limit = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("up_os_t0", t, 4'b0001);
    tick();
    chk("up_os_t1", t, 4'b0011);
    tick();
    chk("up_os_q", q, 2);
    chk("up_os_done", done, 1);
    chk("up_os_t2", t, 0);
    tick();

    // Stop coincident with terminal: no done
    force_q(4'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_term_q", q, 2);
    chk("stop_term_done", done, 0);
    chk("stop_term_t", t, 0);
    tick();
    chk("stop_term_done2", done, 0);

    // limit 0 free-run: hold 0, wrap every cycle, both directions
    one_shot = 1'b0; limit = 4'd0; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lim0_dn_wrap", wrap, 1);
    chk("lim0_dn_t", t, 0);
    chk("lim0_dn_busy", busy, 1);
    tick();
    chk("lim0_dn_wrap2", wrap, 1);
    dir = 1'b1;
    tick();
    chk("lim0_up_wrap", wrap, 1);
    chk("lim0_up_q", q, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // start and load together: start wins
    start = 1'b1; load = 1'b1; load_val = 4'b0110;
    tick();
    start = 1'b0; load = 1'b0;
    chk("prio_clr", ff_clr, 1);
    chk("prio_t", t, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Reset mid-run at q=5
    limit = 4'd15; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_q5", q, 5);
    chk("mid_t5", t, 4'b0011);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst_t", t, 0);
    chk("mid_rst_en", ff_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wrap", wrap, 0);
    chk("mid_rst_done", done, 0);
    tick();
    clr_n = 1'b1;
    tick();
    chk("post_rst_q", q, 5);
    chk("post_rst_busy", busy, 0);
    load = 1'b1; load_val = 4'b0011;
    tick();
    load = 1'b0;
    chk("post_rst_load_t", t, 4'b0110);
    tick();
    chk("post_rst_load_q", q, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
